// File: rtl/ctrl_pipeline_if.sv
// Decode/control bus between the IF/ID register (master) and ctrl_pipeline (slave).
interface ctrl_pipeline_if #(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4
);
    localparam int CTRL_W = 10 + ALUOP_W;

    logic [INSTR_W-1:0] instr_d;
    logic               valid_d;
    logic [CTRL_W-1:0]  ctrl_d;
    logic [CTRL_W-1:0]  ctrl_e;
    logic [CTRL_W-1:0]  ctrl_m;
    logic [CTRL_W-1:0]  ctrl_w;
    logic [REG_AW-1:0]  a3_e;
    logic [REG_AW-1:0]  a3_m;
    logic [REG_AW-1:0]  a3_w;
    logic               stall;
    logic [1:0]         fwd_rs_d;
    logic [1:0]         fwd_rt_d;
    logic [1:0]         fwd_rs_e;
    logic [1:0]         fwd_rt_e;

    modport master (
        output instr_d, valid_d,
        input  ctrl_d, ctrl_e, ctrl_m, ctrl_w, a3_e, a3_m, a3_w,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
    );

    modport slave (
        input  instr_d, valid_d,
        output ctrl_d, ctrl_e, ctrl_m, ctrl_w, a3_e, a3_m, a3_w,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
    );
endinterface

// File: rtl/ctrl_pipeline.sv
// MIPS pipeline control: D-stage decode, E/M/W control registers, Tuse/Tnew
// hazard detection and forwarding selects. FWD_EN=0 gives a stall-only pipeline.
module ctrl_pipeline #(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4,
    parameter bit FWD_EN  = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    ctrl_pipeline_if.slave bus
);
    localparam int CTRL_W = 10 + ALUOP_W;
    localparam int RW_BIT = ALUOP_W + 9;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_BEQ = 6'b000100, OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] OP_SB = 6'b101000, OP_LB = 6'b100000;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_SLLV = 6'b000100;
    localparam logic [5:0] F_SLT = 6'b101010, F_JR = 6'b001000;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(4'b0000);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(4'b0001);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4'b0010);
    localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(4'b0011);
    localparam logic [ALUOP_W-1:0] ALU_SLLV = ALUOP_W'(4'b0100);
    localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(4'b1001);

    // Tuse of 3 means "operand not read": it can never be below any Tnew.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT, DST_RA} dst_e;

    // Flag order: RegWrite MemtoReg MemWrite ALUSrc ExtOp Byte Branch JEn Jal Jr.
    function automatic logic [CTRL_W-1:0] mk_ctrl(input logic [9:0] flags,
                                                  input logic [ALUOP_W-1:0] op);
        return {flags, op};
    endfunction

    function automatic logic src_hit(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] a3,
                                     input logic rw);
        return rw && (src != '0) && (src == a3);
    endfunction

    // A matching stage blocks older stages; it supplies data only once its value is ready.
    function automatic logic [1:0] pick(input logic h_e, input logic r_e, input logic h_m,
                                        input logic r_m, input logic h_w);
        if (h_e) return r_e ? 2'd1 : 2'd0;
        if (h_m) return r_m ? 2'd2 : 2'd0;
        if (h_w) return 2'd3;
        return 2'd0;
    endfunction

    logic [5:0]        opcode, funct;
    logic [REG_AW-1:0] rs_f, rt_f, rd_f, src_rs, src_rt, dec_a3;
    logic [CTRL_W-1:0] dec_ctrl;
    dst_e              dst_sel;
    logic [1:0]        dec_tnew, tuse_rs, tuse_rt;
    logic              unused_instr;

    logic [CTRL_W-1:0] ctrl_e_q, ctrl_e_d, ctrl_m_q, ctrl_m_d, ctrl_w_q, ctrl_w_d;
    logic [REG_AW-1:0] a3_e_q, a3_e_d, a3_m_q, a3_m_d, a3_w_q, a3_w_d;
    logic [REG_AW-1:0] rs_e_q, rs_e_d, rt_e_q, rt_e_d;
    logic [1:0]        tnew_e_q, tnew_e_d, tnew_m_q, tnew_m_d;

    logic rw_e, rw_m, rw_w, stall_req;
    logic hrs_e, hrs_m, hrs_w, hrt_e, hrt_m, hrt_w;
    logic ers_m, ers_w, ert_m, ert_w;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    assign opcode       = bus.instr_d[31:26];
    assign funct        = bus.instr_d[5:0];
    assign rs_f         = bus.instr_d[21 +: REG_AW];
    assign rt_f         = bus.instr_d[16 +: REG_AW];
    assign rd_f         = bus.instr_d[11 +: REG_AW];
    assign unused_instr = ^bus.instr_d;

    // Decode the D-stage instruction into control word, destination kind, Tnew and Tuse.
    always_comb begin
        // NOTE: every signal this block drives gets a default first, so no path infers a latch.
        dec_ctrl = '0;
        dst_sel  = DST_NONE;
        dec_tnew = 2'd0;
        tuse_rs  = TUSE_NONE;
        tuse_rt  = TUSE_NONE;
        if (bus.valid_d) begin
            case (opcode)
                OP_RTYPE: begin
                    case (funct)
                        F_ADD, F_SUB, F_SLLV, F_SLT: begin
                            dec_ctrl = mk_ctrl(10'b1000000000,
                                               (funct == F_ADD)  ? ALU_ADD  :
                                               (funct == F_SUB)  ? ALU_SUB  :
                                               (funct == F_SLLV) ? ALU_SLLV : ALU_SLT);
                            dst_sel  = DST_RD;
                            dec_tnew = 2'd1;
                            tuse_rs  = 2'd1;
                            tuse_rt  = 2'd1;
                        end
                        F_JR: begin
                            dec_ctrl = mk_ctrl(10'b0000000001, ALU_ADD);
                            tuse_rs  = 2'd0;
                        end
                        default: ;
                    endcase
                end
                OP_BEQ: begin
                    dec_ctrl = mk_ctrl(10'b0000001000, ALU_SUB);
                    tuse_rs  = 2'd0;
                    tuse_rt  = 2'd0;
                end
                OP_ORI:  begin dec_ctrl = mk_ctrl(10'b1001000000, ALU_OR);  dst_sel = DST_RT;
                               dec_tnew = 2'd1; tuse_rs = 2'd1; end
                OP_LUI:  begin dec_ctrl = mk_ctrl(10'b1001000000, ALU_LUI); dst_sel = DST_RT;
                               dec_tnew = 2'd1; end
                OP_ADDI: begin dec_ctrl = mk_ctrl(10'b1001100000, ALU_ADD); dst_sel = DST_RT;
                               dec_tnew = 2'd1; tuse_rs = 2'd1; end
                OP_LW:   begin dec_ctrl = mk_ctrl(10'b1101100000, ALU_ADD); dst_sel = DST_RT;
                               dec_tnew = 2'd2; tuse_rs = 2'd1; end
                OP_LB:   begin dec_ctrl = mk_ctrl(10'b1101110000, ALU_ADD); dst_sel = DST_RT;
                               dec_tnew = 2'd2; tuse_rs = 2'd1; end
                OP_SW:   begin dec_ctrl = mk_ctrl(10'b0011100000, ALU_ADD);
                               tuse_rs = 2'd1; tuse_rt = 2'd2; end
                OP_SB:   begin dec_ctrl = mk_ctrl(10'b0011110000, ALU_ADD);
                               tuse_rs = 2'd1; tuse_rt = 2'd2; end
                OP_J:    dec_ctrl = mk_ctrl(10'b0000000100, ALU_ADD);
                OP_JAL:  begin dec_ctrl = mk_ctrl(10'b1000000110, ALU_ADD); dst_sel = DST_RA; end
                default: ;
            endcase
        end
    end

    // Destination and source registers; operands that are not read are reported as $0.
    always_comb begin
        case (dst_sel)
            DST_RD:  dec_a3 = rd_f;
            DST_RT:  dec_a3 = rt_f;
            DST_RA:  dec_a3 = REG_AW'(31);
            default: dec_a3 = '0;
        endcase
        src_rs = (tuse_rs != TUSE_NONE) ? rs_f : '0;
        src_rt = (tuse_rt != TUSE_NONE) ? rt_f : '0;
    end

    assign rw_e  = ctrl_e_q[RW_BIT];
    assign rw_m  = ctrl_m_q[RW_BIT];
    assign rw_w  = ctrl_w_q[RW_BIT];
    assign hrs_e = src_hit(src_rs, a3_e_q, rw_e);
    assign hrs_m = src_hit(src_rs, a3_m_q, rw_m);
    assign hrs_w = src_hit(src_rs, a3_w_q, rw_w);
    assign hrt_e = src_hit(src_rt, a3_e_q, rw_e);
    assign hrt_m = src_hit(src_rt, a3_m_q, rw_m);
    assign hrt_w = src_hit(src_rt, a3_w_q, rw_w);
    assign ers_m = src_hit(rs_e_q, a3_m_q, rw_m);
    assign ers_w = src_hit(rs_e_q, a3_w_q, rw_w);
    assign ert_m = src_hit(rt_e_q, a3_m_q, rw_m);
    assign ert_w = src_hit(rt_e_q, a3_w_q, rw_w);

    // Stall request and forwarding selects for the D and E operands.
    always_comb begin
        stall_req = 1'b0;
        fwd_rs_d  = 2'd0;
        fwd_rt_d  = 2'd0;
        fwd_rs_e  = 2'd0;
        fwd_rt_e  = 2'd0;
        if (FWD_EN) begin
            stall_req = (hrs_e && (tuse_rs < tnew_e_q)) || (hrs_m && (tuse_rs < tnew_m_q)) ||
                        (hrt_e && (tuse_rt < tnew_e_q)) || (hrt_m && (tuse_rt < tnew_m_q));
            fwd_rs_d  = pick(hrs_e, tnew_e_q == 2'd0, hrs_m, tnew_m_q == 2'd0, hrs_w);
            fwd_rt_d  = pick(hrt_e, tnew_e_q == 2'd0, hrt_m, tnew_m_q == 2'd0, hrt_w);
            fwd_rs_e  = pick(1'b0, 1'b0, ers_m, tnew_m_q == 2'd0, ers_w);
            fwd_rt_e  = pick(1'b0, 1'b0, ert_m, tnew_m_q == 2'd0, ert_w);
        end else begin
            stall_req = hrs_e || hrs_m || hrs_w || hrt_e || hrt_m || hrt_w;
        end
    end

    // Next pipeline contents: a stall injects an all-zero bubble into E while M and W advance.
    always_comb begin
        ctrl_e_d = stall_req ? '0 : dec_ctrl;
        a3_e_d   = stall_req ? '0 : dec_a3;
        tnew_e_d = stall_req ? '0 : dec_tnew;
        rs_e_d   = stall_req ? '0 : src_rs;
        rt_e_d   = stall_req ? '0 : src_rt;
        ctrl_m_d = ctrl_e_q;
        a3_m_d   = a3_e_q;
        tnew_m_d = (tnew_e_q == 2'd0) ? 2'd0 : 2'(tnew_e_q - 2'd1);
        ctrl_w_d = ctrl_m_q;
        a3_w_d   = a3_m_q;
    end

    // E/M/W registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignment so every stage samples the old value.
        if (!reset) begin
            ctrl_e_q <= '0; a3_e_q <= '0; tnew_e_q <= '0; rs_e_q <= '0; rt_e_q <= '0;
            ctrl_m_q <= '0; a3_m_q <= '0; tnew_m_q <= '0;
            ctrl_w_q <= '0; a3_w_q <= '0;
        end else begin
            ctrl_e_q <= ctrl_e_d; a3_e_q <= a3_e_d; tnew_e_q <= tnew_e_d;
            rs_e_q   <= rs_e_d;   rt_e_q <= rt_e_d;
            ctrl_m_q <= ctrl_m_d; a3_m_q <= a3_m_d; tnew_m_q <= tnew_m_d;
            ctrl_w_q <= ctrl_w_d; a3_w_q <= a3_w_d;
        end
    end

    assign bus.ctrl_d   = dec_ctrl;
    assign bus.ctrl_e   = ctrl_e_q;
    assign bus.ctrl_m   = ctrl_m_q;
    assign bus.ctrl_w   = ctrl_w_q;
    assign bus.a3_e     = a3_e_q;
    assign bus.a3_m     = a3_m_q;
    assign bus.a3_w     = a3_w_q;
    assign bus.stall    = stall_req;
    assign bus.fwd_rs_d = fwd_rs_d;
    assign bus.fwd_rt_d = fwd_rt_d;
    assign bus.fwd_rs_e = fwd_rs_e;
    assign bus.fwd_rt_e = fwd_rt_e;
endmodule
